// File: rtl/adc_capture.sv
// Dual-channel 8-bit ADC capture into a circular RAM buffer: pre-trigger fill,
// level/edge trigger, post-trigger fill, then freeze. Define AUTO_TRIG_EN for a forced trigger.
module adc_capture #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   adc_cfg,
  input  logic [7:0]    adc_a,
  input  logic [7:0]    adc_b,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] trig_addr,
  output logic [15:0]   status
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        arm, arm_q, arm_rise, edge_sel, src_sel;
  logic [7:0]  level, dec, cur, prev_q, a_q, b_q, dec_cnt;
  logic [11:0] p_raw;
  logic [AW:0] p_cnt, q_cnt, cnt_q, cnt_inc;
  logic        active, samp, rise_hit, fall_hit, trig_hit, auto_hit, fire;
  logic        cfg_unused;

  assign arm      = adc_cfg[0];
  assign edge_sel = adc_cfg[1];
  assign src_sel  = adc_cfg[2];
  assign level    = adc_cfg[15:8];
  assign dec      = adc_cfg[23:16];
  assign p_raw    = {adc_cfg[31:24], 4'b0000};
  assign arm_rise = arm & ~arm_q;

  // Pre-trigger length is clamped so at least 16 post-trigger words remain.
  always_comb begin
    if (int'(p_raw) > DEPTH - 16) p_cnt = (AW+1)'(DEPTH - 16);
    else                          p_cnt = (AW+1)'(p_raw);
    q_cnt = (AW+1)'(DEPTH) - p_cnt;
  end

  assign active   = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign samp     = active && (dec_cnt == 8'd0);
  assign cur      = src_sel ? b_q : a_q;
  assign rise_hit = (prev_q < level) && (cur >= level);
  assign fall_hit = (prev_q >= level) && (cur < level);
  assign trig_hit = edge_sel ? fall_hit : rise_hit;
  assign cnt_inc  = cnt_q + (AW+1)'(1);

`ifdef AUTO_TRIG_EN
  logic [15:0] to_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                to_cnt <= 16'd0;
    else if (state_q != S_WAIT) to_cnt <= 16'd0;
    else if (samp)             to_cnt <= to_cnt + 16'd1;
  end
  assign auto_hit   = samp && adc_cfg[3] && (to_cnt == 16'hFFFF);
  assign cfg_unused = ^adc_cfg[7:4];
`else
  assign auto_hit   = 1'b0;
  assign cfg_unused = ^adc_cfg[7:3];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    if (!arm) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (arm_rise) state_d = (p_cnt == '0) ? S_WAIT : S_PRE;
        S_PRE:  if (samp && cnt_inc == p_cnt) state_d = S_WAIT;
        S_WAIT: if (samp && (trig_hit || auto_hit)) begin
                  state_d = S_POST;
                  fire    = 1'b1;
                end
        S_POST: if (samp && cnt_inc == q_cnt) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // wr_en is a one-cycle write strobe with wr_addr/wr_data valid in the same
  // cycle; the RAM always accepts, so there is no ready/back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q     <= 1'b0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      prev_q    <= 8'd0;
      dec_cnt   <= 8'd0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      wr_addr   <= '0;
      trig_addr <= '0;
      cnt_q     <= '0;
    end else begin
      arm_q <= arm;
      a_q   <= adc_a;
      b_q   <= adc_b;
      if (samp) prev_q <= cur;
      if (!active)               dec_cnt <= 8'd0;
      else if (dec_cnt == 8'd0)  dec_cnt <= dec;
      else                       dec_cnt <= dec_cnt - 8'd1;
      // An abort in the sample cycle suppresses that write.
      wr_en <= samp && arm;
      if (samp) wr_data <= DW'({b_q, a_q});
      if (arm_rise)   wr_addr <= '0;
      else if (wr_en) wr_addr <= wr_addr + AW'(1);
      if (fire) trig_addr <= wr_addr + AW'(wr_en);
      if (arm_rise)  cnt_q <= '0;
      else if (fire) cnt_q <= (AW+1)'(1);
      else if (samp && (state_q == S_PRE || state_q == S_POST)) cnt_q <= cnt_inc;
    end
  end

  assign status = {12'(trig_addr), state_q == S_DONE, state_q};

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: stimulus pushes expected {cycle, addr, data}
// writes; a negedge monitor pops and compares every wr_en strobe.
module tb_adc_capture;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int W  = 32 + AW + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   adc_cfg;
  logic [7:0]    adc_a, adc_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr, trig_addr;
  logic [DW-1:0] wr_data;
  logic [15:0]   status;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  adc_capture #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .adc_cfg(adc_cfg), .adc_a(adc_a), .adc_b(adc_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .trig_addr(trig_addr), .status(status)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus patterns per test, indexed by drive cycle n since arm
  function automatic logic [7:0] fa(input int mode, input int n);
    case (mode)
      2, 4:    return 8'(n);
      3:       return (n < 200) ? 8'h7F : 8'h80;
      5:       return (n == 5 || n >= 30) ? 8'h90 : 8'h10;
      default: return 8'h10;
    endcase
  endfunction

  function automatic logic [7:0] fb(input int mode, input int n);
    case (mode)
      2:       return ~8'(n);
      4:       return 8'h10;
      3:       return 8'h55;
      5:       return 8'hAA;
      default: return 8'h20;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  // driver: arm with cfg, drive n_drive cycles; sample j is taken from drive
  // cycle j*(dec+1) and shows on wr_data two clocks after it was driven
  task automatic run(input logic [31:0] cfg, input int mode, input int n_drive, input int n_exp);
    int step;
    int c0;
    step = int'(cfg[23:16]) + 1;
    @(posedge clk); #1;
    c0 = cyc;
    for (int j = 0; j < n_exp; j++) begin
      int n;
      n = j * step;
      exp_q.push_back({32'(c0 + 2 + n), 12'(j % 4096), fb(mode, n), fa(mode, n)});
    end
    for (int n = 0; n < n_drive; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      adc_cfg = cfg;
      adc_a   = fa(mode, n);
      adc_b   = fb(mode, n);
    end
  endtask

  task automatic abort_and_idle(input string name, input int k);
    @(posedge clk); #1;
    adc_cfg = 32'd0;
    @(posedge clk); #1;
    check({name, "_idle_next_clk"}, 32'(status[2:0]), 32'd0);
    repeat (k) @(posedge clk);
    #1;
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (wr_en) begin
      logic [W-1:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write got cyc=%0d addr=%0d data=%0h want no write", cyc, wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({32'(cyc), wr_addr, wr_data} !== e) begin
          n_bad++;
          $display("FAIL write got cyc=%0d addr=%0d data=%0h want cyc=%0d addr=%0d data=%0h",
                   cyc, wr_addr, wr_data, e[W-1 -: 32], e[DW +: AW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; adc_cfg = 32'd0; adc_a = 8'd0; adc_b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_status", 32'(status), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // dec=3, pre=0, ramp on A, unreachable level: write every 4th clk, then abort
    run({8'd0, 8'd3, 8'hFF, 8'h01}, 2, 40, 10);
    check("dec_state_wait", 32'(status[2:0]), 32'd2);
    abort_and_idle("dec", 20);

    // falling edge on B held below level: no trigger, address wraps 4095 -> 0
    run({8'd0, 8'd0, 8'h80, 8'h07}, 4, 4100, 4099);
    check("notrig_state_wait", 32'(status[2:0]), 32'd2);
    check("notrig_trig_addr", 32'(trig_addr), 32'd0);
    abort_and_idle("notrig", 10);

    // pre=4, rising 0x80 on A at sample 200: 64 pre writes, 4032 post writes
    run({8'd4, 8'd0, 8'h80, 8'h01}, 3, 4240, 4232);
    check("full_status", 32'(status), 32'h0C8C);
    check("full_trig_addr", 32'(trig_addr), 32'd200);
    check("full_oldest_addr", 32'(wr_addr), 32'd136);
    check("full_wr_en_frozen", 32'(wr_en), 32'd0);
    abort_and_idle("full", 5);
    check("abort_done_cleared", 32'(status[3]), 32'd0);
    check("abort_trig_holds", 32'(trig_addr), 32'd200);

    // pulse during PRE ignored, first edge after P=16 writes latched; reset mid-POST
    run({8'd1, 8'd0, 8'h80, 8'h01}, 5, 110, 108);
    check("pre_ignore_status", 32'(status), 32'h01E3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    adc_cfg = 32'd0;
    #1;
    check("midpost_rst_wr_en", 32'(wr_en), 32'd0);
    check("midpost_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("midpost_rst_status", 32'(status), 32'd0);
    check("midpost_rst_trig", 32'(trig_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midpost_idle_after", 32'(status[2:0]), 32'd0);
    check("midpost_drained", 32'(exp_q.size()), 32'd0);

`ifdef AUTO_TRIG_EN
    // auto=1, no real edge: forced trigger on the 65536th WAIT sample
    run({8'd0, 8'd0, 8'hFF, 8'h09}, 6, 65540, 65539);
    check("auto_state_post", 32'(status[2:0]), 32'd3);
    check("auto_trig_addr", 32'(trig_addr), 32'd4095);
    abort_and_idle("auto", 10);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
